rom_port_arbiter: RTL
=====================

# rom_port_arbiter

Shares the single combinational instruction ROM port between two requesters: the instruction-fetch stage (`if_*`) and a data-side reader (`dr_*`) used for constant-table loads and the debug dump path. Registers the ROM address and read data, so the ROM's combinational path is isolated from both requesters. Arbitrates round-robin with fetch preferred after reset. Flags misaligned and out-of-window addresses. Sits between the PC/fetch logic and the ROM in the CPU top level.

## Interface
- `ROM_BASE`, 32'h0040_0000, byte address of ROM word 0.
- `ROM_AW`, 6, ROM word-address width (64 words; word index = `addr[ROM_AW+1:2]`).
- `CHECK_RANGE`, 1, when 1 compare `addr[31:ROM_AW+2]` against `ROM_BASE[31:ROM_AW+2]`; when 0 never flag range.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  32  fetch byte address; stable while `if_req`.
- `if_gnt`  out  1  combinational grant, same cycle as accepted request.
- `if_rvalid`  out  1  one-cycle response strobe for fetch.
- `dr_req`, `dr_addr`, `dr_gnt`, `dr_rvalid`  same as `if_*` for the data reader.
- `rdata`  out  32  registered response data, valid when either `*_rvalid`.
- `rerr`  out  1  response error (misaligned or out of window), qualifies `*_rvalid`.
- `rom_addr`  out  32  address to ROM (registered).
- `rom_data`  in  32  ROM combinational read data.

## Operation
- Grant, cycle t: if exactly one request is active, grant it. If both are active, grant the requester that was not granted last (`last_dr` register). Only one grant per cycle. Grants are combinational from `*_req` and `last_dr`; no grant while `reset` is low.
- On a grant edge: `rom_addr <= granted addr`, `s1_valid <= 1`, `s1_src <= dr`, `s1_err <= err(addr)`, and `last_dr` updates.
- `err(addr)` = (`addr[1:0] != 0`) OR (`CHECK_RANGE` AND high-bits mismatch).
- Response stage, edge ending cycle t+1 when `s1_valid`:
  - `rdata <= s1_err ? 0 : rom_data`.
  - `rerr <= s1_err`.
  - Assert `if_rvalid` or `dr_rvalid` per `s1_src` for exactly one cycle.
- When `s1_valid` is 0, `rdata` and `rerr` hold their values and both rvalid strobes are 0.
- Pipeline depth is fixed at 2 and there is no backpressure. The requester must accept the response in the cycle `*_rvalid` is high.
- The pipeline state (`idle` / `s1` / `resp`) is implicit in the `s1_valid` and `rvalid` registers. There is no other FSM.

## Timing
- Latency: request granted in cycle t produces its response in cycle t+2. Throughput is 1 access per cycle, sustained.
- Back-to-back with both requesting every cycle: grants alternate IF, DR, IF, DR, and so on. Responses alternate in the same order.
- A requester keeping `req` high after its grant is treated as a new request in the next cycle.
- A request dropped before grant is allowed and produces no response.
- Reset values: `rom_addr=0`, `rdata=0`, `rerr=0`, `if_rvalid=0`, `dr_rvalid=0`, `s1_valid=0`, `last_dr=1` (fetch wins the first tie).
- Reset asserted mid-operation discards in-flight accesses. No rvalid is issued for them after release.
- First grant is possible in the first cycle after `reset` deasserts.
- Address changes while `req` is high and before grant are allowed; the address is sampled only on the grant edge.

## Structure
- Shared package (`cpu_pkg`): `ROM_BASE` and `ROM_AW` defaults, plus a 1-bit source encoding `SRC_IF=0`, `SRC_DR=1`.
- Single flat module. The round-robin 2-way picker may be a sub-module `rr_pick2` (inputs `req[1:0]`, `last`; output one-hot `gnt[1:0]`), reused later by the data-bus arbiter.

## Test plan
- Reset: hold `reset` low with both requests high. Required: no grants, all outputs 0. Release; cycle 1 grants IF.
- Single fetch: `if_addr=32'h0040_0008`, ROM word 2 = `32'h3C094000`. Required: `if_gnt` at t, `if_rvalid` at t+2, `rdata=32'h3C094000`, `rerr=0`.
- Contention: both requesting continuously for 6 cycles (`if_addr` word 0, `dr_addr` word 13). Required: grants IF, DR, IF, DR, IF, DR, and responses match per source, each 2 cycles later.
- Errors: `dr_addr=32'h0040_0006` gives `dr_rvalid` with `rerr=1`, `rdata=0`. `if_addr=32'h1000_0000` with `CHECK_RANGE=1` gives `rerr=1`; with `CHECK_RANGE=0` it returns ROM word 0, `rerr=0`.
- Reset mid-flight: grant IF at t, assert `reset` at t+1. Required: no `if_rvalid` ever for that access; outputs return to reset values immediately.
- Hold behaviour: `dr_req` held with no contention for 4 cycles. Required: 4 grants and 4 consecutive `dr_rvalid` pulses; `if_rvalid` stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM window defaults and requester source encoding.
package cpu_pkg;

    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam int          ROM_AW   = 6;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DR = 1'b1
    } src_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; bit 0 wins a tie when bit 1 was granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM port between fetch and data reader.
// Two-stage registered path: grant/address, then response capture.
module rom_port_arbiter
    import cpu_pkg::*;
#(
    parameter logic [31:0] ROM_BASE    = cpu_pkg::ROM_BASE,
    parameter int          ROM_AW      = cpu_pkg::ROM_AW,
    parameter logic        CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        dr_req,
    input  logic [31:0] dr_addr,
    output logic        dr_gnt,
    output logic        dr_rvalid,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_any;
    logic [31:0] w_addr;
    logic        w_misalign;
    logic        w_oow;
    logic        w_err;

    logic        r_last_dr;
    logic        r_s1_valid;
    src_e        r_s1_src;
    logic        r_s1_err;
    logic [31:0] r_rom_addr;
    logic [31:0] r_rdata;
    logic        r_rerr;
    logic        r_if_rvalid;
    logic        r_dr_rvalid;

    // Requests are masked during reset so no grant escapes.
    assign w_req = {dr_req, if_req} & {2{reset}};

    rr_pick2 u_pick (
        .req  (w_req),
        .last (r_last_dr),
        .gnt  (w_gnt)
    );

    assign if_gnt = w_gnt[0];
    assign dr_gnt = w_gnt[1];
    assign w_any  = |w_gnt;
    assign w_addr = w_gnt[1] ? dr_addr : if_addr;

    assign w_misalign = |w_addr[1:0];
    assign w_oow      = CHECK_RANGE &&
        (w_addr[31:ROM_AW+2] != ROM_BASE[31:ROM_AW+2]);
    assign w_err      = w_misalign | w_oow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_dr  <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_src   <= SRC_IF;
            r_s1_err   <= 1'b0;
            r_rom_addr <= 32'h0;
        end else begin
            r_s1_valid <= w_any;
            if (w_any) begin
                r_rom_addr <= w_addr;
                r_s1_src   <= w_gnt[1] ? SRC_DR : SRC_IF;
                r_s1_err   <= w_err;
                r_last_dr  <= w_gnt[1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata     <= 32'h0;
            r_rerr      <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dr_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= r_s1_valid && (r_s1_src == SRC_IF);
            r_dr_rvalid <= r_s1_valid && (r_s1_src == SRC_DR);
            if (r_s1_valid) begin
                r_rdata <= r_s1_err ? 32'h0 : rom_data;
                r_rerr  <= r_s1_err;
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rdata     = r_rdata;
    assign rerr      = r_rerr;
    assign if_rvalid = r_if_rvalid;
    assign dr_rvalid = r_dr_rvalid;

endmodule
